// File: rtl/pixel_buffer_pkg.sv
// Shared project types for the pixel buffer path: pixel identifiers,
// 16-bit colour, the queued entry layout and the frame size.
package pixel_buffer_pkg;

    localparam int unsigned PIXEL_ID_W  = 19;
    localparam int unsigned COLOR_W     = 16;
    localparam int unsigned SRAM_ADDR_W = PIXEL_ID_W + 1;

    // Pixels in one 640x480 frame.
    localparam int unsigned DEFAULT_NUM_PIX = 307200;

    typedef logic [PIXEL_ID_W-1:0]  pixelID_t;
    typedef logic [COLOR_W-1:0]     color16_t;
    typedef logic [SRAM_ADDR_W-1:0] sram_addr_t;

    typedef struct packed {
        pixelID_t pixelID;
        color16_t color16;
    } pixel_buffer_entry_t;

    localparam int unsigned ENTRY_W = $bits(pixel_buffer_entry_t);

    // The frame-buffer half selects the top address bit above the pixel index.
    function automatic sram_addr_t make_sram_addr(input logic buf_sel, input pixelID_t pixel_id);
        return {buf_sel, pixel_id};
    endfunction

endpackage

// File: rtl/fifo.sv
// Generic synchronous FIFO with combinational head read. Push is refused
// when full (registered count), pop is refused when empty, so a full FIFO
// never accepts a push even if it is being popped in the same cycle.
module fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = wr_en && !full;
    assign do_pop  = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage write; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer advance; DEPTH is a power of two so natural wrap is modulo DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // Occupancy tracking; simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else begin
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    a_count_bound: assert property (@(posedge clk) disable iff (rst) count <= CNT_W'(DEPTH));

endmodule

// File: rtl/pixel_buffer.sv
// Pixel buffer between the colour converter and the SRAM write port.
// Queues {pixelID, colour} entries, presents the head as an SRAM write,
// counts written pixels per frame and flips the double-buffer half at the
// end of each frame.
module pixel_buffer
    import pixel_buffer_pkg::*;
#(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned NUM_PIX = DEFAULT_NUM_PIX
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cc_to_pixel_buffer_valid,
    input  logic [ENTRY_W-1:0] cc_to_pixel_buffer_data,
    output logic               cc_to_pixel_buffer_stall,
    output logic               pb_to_sram_valid,
    output logic [19:0]        pb_to_sram_addr,
    output logic [15:0]        pb_to_sram_data,
    input  logic               pb_to_sram_stall,
    output logic               frame_done,
    output logic               disp_buf_sel
);

    localparam pixelID_t LAST_PIX = pixelID_t'(NUM_PIX - 1);

    logic                fifo_full;
    logic                fifo_empty;
    logic [ENTRY_W-1:0]  head_raw;
    pixel_buffer_entry_t head;
    logic                push;
    logic                pop;
    logic                last_pix;
    pixelID_t            pix_cnt;
    logic                buf_sel;
    logic                frame_done_q;

    assign push     = cc_to_pixel_buffer_valid && !fifo_full;
    assign pop      = !fifo_empty && !pb_to_sram_stall;
    assign head     = pixel_buffer_entry_t'(head_raw);
    assign last_pix = pop && (pix_cnt == LAST_PIX);

    assign cc_to_pixel_buffer_stall = cc_to_pixel_buffer_valid && fifo_full;
    assign pb_to_sram_valid         = !fifo_empty;
    // buf_sel is applied at the pop, so entries queued across a frame
    // boundary land in the half that is current when they are written.
    assign pb_to_sram_addr          = make_sram_addr(buf_sel, head.pixelID);
    assign pb_to_sram_data          = head.color16;
    assign frame_done               = frame_done_q;
    assign disp_buf_sel             = ~buf_sel;

    fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push),
        .wr_data (cc_to_pixel_buffer_data),
        .rd_en   (pop),
        .rd_data (head_raw),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Count written pixels; wrap to zero on the last pixel of a frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_cnt <= '0;
        end else if (pop) begin
            pix_cnt <= last_pix ? '0 : pix_cnt + pixelID_t'(1);
        end
    end

    // End-of-frame pulse and buffer swap, both one cycle after the last write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_done_q <= 1'b0;
            buf_sel      <= 1'b0;
        end else begin
            frame_done_q <= last_pix;
            if (last_pix) begin
                buf_sel <= ~buf_sel;
            end
        end
    end

    a_head_stable: assert property (@(posedge clk) disable iff (rst)
        (pb_to_sram_valid && pb_to_sram_stall) |=>
        (pb_to_sram_valid && $stable(pb_to_sram_addr) && $stable(pb_to_sram_data)));

    a_no_stall_when_idle: assert property (@(posedge clk) disable iff (rst)
        !cc_to_pixel_buffer_valid |-> !cc_to_pixel_buffer_stall);

endmodule

// File: tb/tb_pixel_buffer.sv
// Scoreboard bench for pixel_buffer with a small frame (NUM_PIX=4).
// The reference model is a queue of accepted entries plus a count of SRAM
// writes since reset; the buffer half of write k is (k / NUM_PIX) mod 2 and
// a frame ends on every NUM_PIX-th write.
module tb_pixel_buffer;
    import pixel_buffer_pkg::*;

    localparam int unsigned DEPTH_TB   = 16;
    localparam int unsigned NUM_PIX_TB = 4;
    localparam int unsigned N_RANDOM   = 10000;

    logic               clk;
    logic               rst;
    logic               cc_valid;
    logic [ENTRY_W-1:0] cc_data;
    logic               cc_stall;
    logic               sram_valid;
    logic [19:0]        sram_addr;
    logic [15:0]        sram_data;
    logic               sram_stall;
    logic               frame_done;
    logic               disp_buf_sel;

    pixel_buffer #(
        .DEPTH   (DEPTH_TB),
        .NUM_PIX (NUM_PIX_TB)
    ) dut (
        .clk                      (clk),
        .rst                      (rst),
        .cc_to_pixel_buffer_valid (cc_valid),
        .cc_to_pixel_buffer_data  (cc_data),
        .cc_to_pixel_buffer_stall (cc_stall),
        .pb_to_sram_valid         (sram_valid),
        .pb_to_sram_addr          (sram_addr),
        .pb_to_sram_data          (sram_data),
        .pb_to_sram_stall         (sram_stall),
        .frame_done               (frame_done),
        .disp_buf_sel             (disp_buf_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    pixel_buffer_entry_t exp_q[$];
    int unsigned wr_idx  = 0;
    logic        pend_fd = 1'b0;
    int unsigned fd_seen = 0;

    int unsigned accepts         = 0;
    bit          stall_seen      = 1'b0;
    int unsigned accepts_at_stall = 0;
    bit          rand_on         = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic buf_of(input int unsigned idx);
        return ((idx / NUM_PIX_TB) % 2) != 0;
    endfunction

    // Monitor: per-cycle frame/display checks, scoreboard pop on each SRAM write.
    always @(negedge clk) begin
        if (rst) begin
            wr_idx  = 0;
            pend_fd = 1'b0;
        end else begin
            logic exp_disp;
            chk("frame_done", 32'(frame_done), 32'(pend_fd));
            if (frame_done) fd_seen++;
            exp_disp = !buf_of(wr_idx);
            chk("disp_buf_sel", 32'(disp_buf_sel), 32'(exp_disp));
            if (sram_valid && !sram_stall) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sram_unexpected: got write addr %0h data %0h, expected no write", sram_addr, sram_data);
                end else begin
                    pixel_buffer_entry_t e;
                    logic [19:0] exp_addr;
                    e = exp_q.pop_front();
                    exp_addr = {buf_of(wr_idx), e.pixelID};
                    chk("sram_addr", 32'(sram_addr), 32'(exp_addr));
                    chk("sram_data", 32'(sram_data), 32'(e.color16));
                end
                pend_fd = ((wr_idx % NUM_PIX_TB) == NUM_PIX_TB - 1);
                wr_idx++;
            end else begin
                pend_fd = 1'b0;
            end
        end
    end

    task automatic push_entry(input pixel_buffer_entry_t e);
        int unsigned waited = 0;
        bit done = 1'b0;
        cc_valid = 1'b1;
        cc_data  = e;
        while (!done) begin
            @(negedge clk);
            if (!cc_stall) begin
                exp_q.push_back(e);
                accepts++;
                done = 1'b1;
            end else begin
                if (!stall_seen) begin
                    stall_seen = 1'b1;
                    accepts_at_stall = accepts;
                end
                waited++;
                if (waited > 1000) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL push_timeout: got stall held 1000 cycles, expected acceptance");
                    done = 1'b1;
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain(input string name);
        int unsigned n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((exp_q.size() != 0 || sram_valid) && n < 2000);
        chk({name, "_queue_empty"}, exp_q.size(), 0);
        chk({name, "_valid_low"}, 32'(sram_valid), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string name);
        chk({name, "_valid"}, 32'(sram_valid), 0);
        chk({name, "_stall"}, 32'(cc_stall), 0);
        chk({name, "_frame_done"}, 32'(frame_done), 0);
        chk({name, "_disp_buf_sel"}, 32'(disp_buf_sel), 1);
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        cc_valid   = 1'b0;
        sram_stall = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic pixel_buffer_entry_t rand_entry();
        pixel_buffer_entry_t e;
        e.pixelID = pixelID_t'($urandom_range(0, DEFAULT_NUM_PIX - 1));
        e.color16 = color16_t'($urandom());
        return e;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        pixel_buffer_entry_t e;

        rst        = 1'b1;
        cc_valid   = 1'b0;
        cc_data    = '0;
        sram_stall = 1'b0;
        #3;
        check_reset_vals("reset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Single entry: one-cycle latency, popped immediately.
        e.pixelID = 19'd5;
        e.color16 = 16'hABCD;
        push_entry(e);
        cc_valid = 1'b0;
        @(negedge clk);
        chk("single_valid", 32'(sram_valid), 1);
        chk("single_addr", 32'(sram_addr), 32'h00005);
        chk("single_data", 32'(sram_data), 32'hABCD);
        @(negedge clk);
        chk("single_valid_after", 32'(sram_valid), 0);
        @(posedge clk);
        #1;

        // Frame boundary: writes 2..5, write 5 lands in the other half.
        fd_seen = 0;
        for (int i = 1; i <= 4; i++) begin
            e.pixelID = pixelID_t'(i);
            e.color16 = color16_t'($urandom());
            push_entry(e);
        end
        cc_valid = 1'b0;
        drain("frame");
        chk("frame_pulses", fd_seen, 1);
        chk("frame_disp_swapped", 32'(disp_buf_sel), 0);

        // Mid-frame reset with 7 entries queued, buf_sel=1 and pix_cnt=3.
        for (int i = 0; i < 2; i++) push_entry(rand_entry());
        cc_valid = 1'b0;
        drain("pre_rst");
        sram_stall = 1'b1;
        for (int i = 0; i < 7; i++) push_entry(rand_entry());
        @(posedge clk);
        #2;
        rst = 1'b1;
        exp_q.delete();
        #1;
        check_reset_vals("midrst");
        @(posedge clk);
        #1;
        rst        = 1'b0;
        cc_valid   = 1'b0;
        sram_stall = 1'b0;
        @(negedge clk);
        chk("midrst_valid_after_release", 32'(sram_valid), 0);
        @(posedge clk);
        #1;
        fd_seen = 0;
        for (int i = 0; i < 3; i++) push_entry(rand_entry());
        cc_valid = 1'b0;
        drain("post_rst3");
        chk("post_rst_no_early_frame", fd_seen, 0);
        push_entry(rand_entry());
        cc_valid = 1'b0;
        drain("post_rst4");
        chk("post_rst_full_frame", fd_seen, 1);

        // Backpressure: 20 back-to-back pushes against a stalled SRAM.
        do_reset();
        sram_stall       = 1'b1;
        stall_seen       = 1'b0;
        accepts          = 0;
        accepts_at_stall = 0;
        fork
            begin
                repeat (40) @(posedge clk);
                #1;
                sram_stall = 1'b0;
            end
        join_none
        for (int i = 0; i < 20; i++) push_entry(rand_entry());
        cc_valid = 1'b0;
        chk("bp_stall_seen", 32'(stall_seen), 1);
        chk("bp_accepts_before_stall", accepts_at_stall, DEPTH_TB);
        drain("bp");

        // Full FIFO with a coincident pop refuses the push, accepts it next cycle.
        sram_stall = 1'b1;
        for (int i = 0; i < 16; i++) push_entry(rand_entry());
        e = rand_entry();
        cc_valid   = 1'b1;
        cc_data    = e;
        sram_stall = 1'b0;
        @(negedge clk);
        chk("full_push_refused", 32'(cc_stall), 1);
        @(negedge clk);
        chk("push_after_pop", 32'(cc_stall), 0);
        if (!cc_stall) exp_q.push_back(e);
        @(posedge clk);
        #1;
        cc_valid = 1'b0;
        drain("full");

        // Random valid and SRAM stall over many frames.
        do_reset();
        fd_seen = 0;
        rand_on = 1'b1;
        fork
            begin
                while (rand_on) begin
                    @(posedge clk);
                    #1;
                    if (rand_on) sram_stall = ($urandom_range(0, 3) == 0);
                end
            end
        join_none
        for (int i = 0; i < N_RANDOM; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                cc_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            push_entry(rand_entry());
        end
        cc_valid = 1'b0;
        rand_on  = 1'b0;
        @(posedge clk);
        #2;
        sram_stall = 1'b0;
        drain("random");
        repeat (2) @(posedge clk);
        #1;
        chk("random_frame_count", fd_seen, N_RANDOM / NUM_PIX_TB);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pixel_buffer.md
PIXEL_BUFFER -- requirements
Module: pixel_buffer

Interface
REQ-001 Parameter DEPTH, default 16: FIFO entries, power of two, at least 4.
REQ-002 Parameter NUM_PIX, default 307200: pixels per frame (640x480).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 cc_to_pixel_buffer_valid  input  1  upstream entry present.
REQ-006 cc_to_pixel_buffer_data  input  $bits(pixel_buffer_entry_t)  {pixelID (19b), color16 (16b)}.
REQ-007 cc_to_pixel_buffer_stall  output  1  upstream must hold its data.
REQ-008 pb_to_sram_valid  output  1  write request present.
REQ-009 pb_to_sram_addr  output  20  {buf_sel, pixelID}.
REQ-010 pb_to_sram_data  output  16  color16 of the head entry.
REQ-011 pb_to_sram_stall  input  1  SRAM write port busy.
REQ-012 frame_done  output  1  one-cycle pulse on the final pixel write of a frame.
REQ-013 disp_buf_sel  output  1  frame-buffer half that the display reads; always the complement of buf_sel.

Function
REQ-014 The upstream transfer SHALL occur on cycles where valid=1 and stall=0; the downstream transfer SHALL occur on cycles where pb_to_sram_valid=1 and pb_to_sram_stall=0.
REQ-015 cc_to_pixel_buffer_stall SHALL equal (count==DEPTH) && cc_to_pixel_buffer_valid, registered-count based. A full FIFO SHALL refuse a push even when a pop occurs in the same cycle.
REQ-016 Each accepted entry SHALL be written at the write pointer; count increments, wrapping the pointer modulo DEPTH.
REQ-017 pb_to_sram_valid SHALL equal (count!=0). Addr and data SHALL come combinationally from the head entry. Latency SHALL be 1 cycle: an entry pushed into an empty FIFO is presented on the next cycle.
REQ-018 When push and pop coincide with 0<count<DEPTH, count SHALL stay unchanged and both pointers SHALL advance.
REQ-019 Head outputs SHALL hold stable while pb_to_sram_stall=1.
REQ-020 No push SHALL occur when full; no pop SHALL occur when empty. Overflow and underflow SHALL be impossible by construction.
REQ-021 pix_cnt (19b) SHALL increment on each downstream transfer. On the transfer where pix_cnt==NUM_PIX-1:
- pix_cnt SHALL go to 0;
- frame_done SHALL pulse in the following cycle;
- buf_sel SHALL toggle in the following cycle.
REQ-022 buf_sel SHALL be sampled per entry at the pop, not at the push. Entries queued across a frame boundary SHALL therefore use the buf_sel current at their write.
REQ-023 The block SHALL NOT reorder or drop entries and SHALL NOT check pixelID against pix_cnt.

Reset
REQ-024 While rst=1 the block SHALL hold:
- count, pointers, pix_cnt: 0;
- buf_sel: 0, so disp_buf_sel=1;
- frame_done: 0;
- pb_to_sram_valid: 0;
- cc_to_pixel_buffer_stall: 0.
REQ-025 Reset mid-frame SHALL discard all queued entries and the partial frame count with no SRAM request in the cycle after release.
REQ-026 FIFO storage SHALL need no reset; only control state is reset.

Structure
REQ-027 pixel_buffer_entry_t, pixelID_t, color16_t and a NUM_PIX constant SHALL reside in the shared project package.
REQ-028 The FIFO SHALL be the existing sub-module fifo, instantiated with width $bits(pixel_buffer_entry_t) and depth DEPTH. Frame counting and buf_sel logic SHALL live in pixel_buffer.

Verification
REQ-029 Single push {pixelID=5, color=16'hABCD}, no stall:
- next cycle valid=1, addr=20'h00005, data=16'hABCD;
- popped that cycle, then valid=0.
REQ-030 pb_to_sram_stall held at 1, 20 back-to-back pushes:
- stall rises after exactly DEPTH=16 accepts;
- upstream data held without loss;
- releasing drains all 20 in order.
REQ-031 Full FIFO, push and pop in the same cycle: push refused, count becomes 15, next cycle push accepted.
REQ-032 With NUM_PIX=4:
- after 4 writes, frame_done pulses once;
- addr bit 19 is 0 for writes 1-4 and 1 for write 5;
- disp_buf_sel goes 1 to 0.
REQ-033 rst asserted with 7 queued entries and pix_cnt=3: outputs reach reset values immediately; after release valid=0 and the next frame needs the full NUM_PIX writes.
REQ-034 Random valid/stall for 10k pixels: scoreboard confirms in-order, lossless output and correct frame_done count.
